// File: rtl/scope_pkg.sv
// Shared encodings for the scope trigger/capture block.
//   mode_e  : acquisition mode as presented on the mode port
//   edge_e  : trigger slope as presented on the triggerEdge port
//   state_e : capture sequencer states
package scope_pkg;

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'd0,
    MODE_AUTO   = 2'd1,
    MODE_SINGLE = 2'd2,
    MODE_RSVD   = 2'd3   // behaves as normal
  } mode_e;

  typedef enum logic {
    EDGE_RISING  = 1'b0,
    EDGE_FALLING = 1'b1
  } edge_e;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  function automatic logic is_auto(input logic [1:0] m);
    return mode_e'(m) == MODE_AUTO;
  endfunction

  function automatic logic is_single(input logic [1:0] m);
    return mode_e'(m) == MODE_SINGLE;
  endfunction

endpackage

// File: rtl/scope_frame_ram.sv
// Two-bank simple dual-port frame store with registered read.
//   clock   : single clock
//   wr_en   : write strobe
//   wr_bank : bank selected for writing
//   wr_addr : column address within the bank (< DEPTH)
//   wr_data : sample to store
//   rd_bank : bank selected for reading
//   rd_addr : column address within the bank (< DEPTH)
//   rd_data : stored sample, valid one cycle after rd_addr
module scope_frame_ram #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 800,
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  localparam int IDX_W = $clog2(2 * DEPTH);
  localparam logic [IDX_W-1:0] BANK_OFS = IDX_W'(DEPTH);

  logic [DATA_W-1:0] mem [2*DEPTH];
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;

  // Banks are stacked back to back, so DEPTH need not be a power of two.
  assign wr_idx = IDX_W'(wr_addr) + (wr_bank ? BANK_OFS : '0);
  assign rd_idx = IDX_W'(rd_addr) + (rd_bank ? BANK_OFS : '0);

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_idx] <= wr_data;
    rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/scope_trigger_capture.sv
// Oscilloscope trigger and frame capture. Samples stream into a ring in the
// capture bank; once a trigger fires and the post-trigger tail is collected
// the banks swap and the display side reads the frame column by column,
// column 0 being PRE samples ahead of the trigger.
//
// state | meaning
// FILL  | collecting the pre-trigger history for a new frame
// ARMED | hunting for the trigger edge (or auto timeout)
// POST  | collecting the post-trigger tail
// WAIT  | single shot frame published, parked until rearm
//
// Ports:
//   clock, reset      : single clock, synchronous active-low reset
//   sampleEn, data    : sample strobe and unsigned ADC sample
//   triggerThreshold  : trigger level
//   hysteresis        : re-arm band around the level
//   triggerEdge       : 0 rising, 1 falling
//   mode              : 0 normal, 1 auto, 2 single, 3 normal
//   hold              : freezes capture and swap
//   rearm             : restarts single shot from WAIT
//   screenX           : display column request
//   screenData        : sample for the requested column, one cycle later
//   resample          : toggles on every bank swap
//   frameValid        : set once the first frame has been published
//   triggered         : one-cycle pulse after the trigger sample is written
module scope_trigger_capture
  import scope_pkg::*;
#(
  parameter int DATA_W  = 12,
  parameter int DEPTH   = 800,
  parameter int PRE     = 100,
  parameter int TIMEOUT = 2000,
  parameter int ADDR_W  = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sampleEn,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] triggerThreshold,
  input  logic [DATA_W-1:0] hysteresis,
  input  logic              triggerEdge,
  input  logic [1:0]        mode,
  input  logic              hold,
  input  logic              rearm,
  input  logic [ADDR_W-1:0] screenX,
  output logic [DATA_W-1:0] screenData,
  output logic              resample,
  output logic              frameValid,
  output logic              triggered
);
  localparam int SEG_W  = $clog2(DEPTH + 1);
  localparam int TMR_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int POST_N = DEPTH - PRE - 1;

  localparam logic [SEG_W-1:0]  PRE_LAST  = SEG_W'((PRE > 0) ? PRE - 1 : 0);
  localparam logic [SEG_W-1:0]  POST_LAST = SEG_W'((POST_N > 0) ? POST_N - 1 : 0);
  localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(TIMEOUT);
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   PRE_X     = (ADDR_W+1)'(PRE);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e state, state_nxt;

  logic              acc, write_en, fire, swap, forced;
  logic              level_hit, arm_hit, enter_fill;
  logic              arm;
  logic [SEG_W-1:0]  seg_cnt;
  logic [TMR_W-1:0]  tmr;
  logic [ADDR_W-1:0] wa, trig_addr, start, start_nxt, trig_src, rd_addr;
  logic [DATA_W:0]   lvl_sum;
  logic [DATA_W-1:0] lvl_lo, lvl_hi, rd_data;
  logic [ADDR_W:0]   trig_ext, rd_sum;
  logic              disp_bank, cap_bank, rd_valid, in_range;

  assign acc      = sampleEn & ~hold;
  assign write_en = reset & acc & (state != ST_WAIT);
  assign cap_bank = ~disp_bank;

  // Hysteresis band edges saturate at 0 and at full scale.
  assign lvl_sum = {1'b0, triggerThreshold} + {1'b0, hysteresis};
  assign lvl_hi  = lvl_sum[DATA_W] ? '1 : lvl_sum[DATA_W-1:0];
  assign lvl_lo  = (triggerThreshold >= hysteresis) ? triggerThreshold - hysteresis : '0;

  always_comb begin
    arm_hit   = data < lvl_lo;
    level_hit = data >= triggerThreshold;
    if (edge_e'(triggerEdge) == EDGE_FALLING) begin
      arm_hit   = data > lvl_hi;
      level_hit = data <= triggerThreshold;
    end
  end

  assign forced = is_auto(mode) && (tmr == '0);
  assign fire   = (state == ST_ARMED) && acc && ((arm && level_hit) || forced);
  assign swap   = (POST_N == 0) ? fire
                                : ((state == ST_POST) && acc && (seg_cnt == POST_LAST));

  // When the tail is empty the swap coincides with the fire, before
  // trig_addr has been captured.
  assign trig_src  = (state == ST_ARMED) ? wa : trig_addr;
  assign trig_ext  = {1'b0, trig_src};
  assign start_nxt = (trig_ext >= PRE_X) ? ADDR_W'(trig_ext - PRE_X)
                                         : ADDR_W'(trig_ext + DEPTH_X - PRE_X);

  always_ff @(posedge clock) begin
    if (!reset) state <= ST_FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_FILL:  if (acc && (seg_cnt == PRE_LAST)) state_nxt = ST_ARMED;
      ST_ARMED: if (fire) state_nxt = ST_POST;
      ST_POST:  state_nxt = ST_POST;
      ST_WAIT:  if (rearm && !hold) state_nxt = ST_FILL;
      default:  state_nxt = ST_FILL;
    endcase
    if (swap) state_nxt = is_single(mode) ? ST_WAIT : ST_FILL;
  end

  assign enter_fill = (state_nxt == ST_FILL) && (state != ST_FILL);

  always_ff @(posedge clock) begin
    if (!reset) begin
      wa         <= '0;
      seg_cnt    <= '0;
      tmr        <= '0;
      arm        <= 1'b0;
      trig_addr  <= '0;
      disp_bank  <= 1'b0;
      start      <= '0;
      resample   <= 1'b0;
      frameValid <= 1'b0;
      triggered  <= 1'b0;
      rd_valid   <= 1'b0;
    end else begin
      triggered <= fire;
      rd_valid  <= frameValid && in_range;

      if (write_en) wa <= (wa == LAST_ADDR) ? '0 : wa + ADDR_W'(1);

      if (state_nxt != state)
        seg_cnt <= '0;
      else if (acc && ((state == ST_FILL) || (state == ST_POST)))
        seg_cnt <= seg_cnt + SEG_W'(1);

      if (enter_fill)
        arm <= 1'b0;
      else if (acc && ((state == ST_FILL) || (state == ST_ARMED)) && arm_hit)
        arm <= 1'b1;

      if ((state == ST_FILL) && (state_nxt == ST_ARMED))
        tmr <= TMR_LOAD;
      else if ((state == ST_ARMED) && acc && !fire && (tmr != '0))
        tmr <= tmr - TMR_W'(1);

      if (fire) trig_addr <= wa;

      if (swap) begin
        disp_bank  <= cap_bank;
        start      <= start_nxt;
        resample   <= ~resample;
        frameValid <= 1'b1;
      end
    end
  end

  // Display read: rotate by the frame start, modulo DEPTH.
  assign in_range = {1'b0, screenX} < DEPTH_X;
  assign rd_sum   = {1'b0, start} + {1'b0, screenX};

  always_comb begin
    rd_addr = '0;
    if (in_range)
      rd_addr = (rd_sum >= DEPTH_X) ? ADDR_W'(rd_sum - DEPTH_X) : rd_sum[ADDR_W-1:0];
  end

  scope_frame_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_frame_ram (
    .clock   (clock),
    .wr_en   (write_en),
    .wr_bank (cap_bank),
    .wr_addr (wa),
    .wr_data (data),
    .rd_bank (disp_bank),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign screenData = rd_valid ? rd_data : '0;

endmodule

// File: tb/tb_scope_trigger_capture.sv
// Bench for scope_trigger_capture: directed scenarios with hand-computed
// expectations, then randomized traffic, all compared every cycle against
// a frame-level model (last DEPTH accepted samples become the display).
module tb_scope_trigger_capture;
  localparam int DATA_W  = 12;
  localparam int DEPTH   = 16;
  localparam int PRE     = 4;
  localparam int TIMEOUT = 20;
  localparam int ADDR_W  = 5;
  localparam int MAXV    = (1 << DATA_W) - 1;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              sampleEn = 1'b0;
  logic [DATA_W-1:0] data = '0;
  logic [DATA_W-1:0] triggerThreshold = 12'd100;
  logic [DATA_W-1:0] hysteresis = 12'd10;
  logic              triggerEdge = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic              hold = 1'b0;
  logic              rearm = 1'b0;
  logic [ADDR_W-1:0] screenX = '0;
  logic [DATA_W-1:0] screenData;
  logic              resample, frameValid, triggered;

  always #5 clock = ~clock;

  scope_trigger_capture #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .PRE(PRE), .TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)
  ) dut (
    .clock(clock), .reset(reset), .sampleEn(sampleEn), .data(data),
    .triggerThreshold(triggerThreshold), .hysteresis(hysteresis),
    .triggerEdge(triggerEdge), .mode(mode), .hold(hold), .rearm(rearm),
    .screenX(screenX), .screenData(screenData), .resample(resample),
    .frameValid(frameValid), .triggered(triggered)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 gathering pre-trigger, 1 hunting, 2 tail, 3 parked (single)
  int  m_phase = 0, m_cnt = 0, m_waited = 0;
  bit  m_arm = 0, m_fv = 0, m_res = 0;
  int  hist[$];
  int  disp[DEPTH];
  int  m_fires = 0, m_fire_val = -1;
  int  exp_scr = 0;
  bit  exp_trig = 0;
  bit  chk_en = 0;

  always @(posedge clock) begin
    int d, thr, hys, lo, hi, sx;
    bit acc, fall, armh, lvl, fire, swap_now;
    d    = int'(data);
    thr  = int'(triggerThreshold);
    hys  = int'(hysteresis);
    sx   = int'(screenX);
    fall = triggerEdge;
    exp_scr  = (m_fv && sx < DEPTH) ? disp[sx] : 0;
    exp_trig = 0;
    if (!reset) begin
      chk_en = 1; exp_scr = 0;
      m_phase = 0; m_cnt = 0; m_waited = 0; m_arm = 0; m_fv = 0; m_res = 0;
      hist.delete();
    end else begin
      acc  = sampleEn && !hold;
      lo   = (thr - hys < 0) ? 0 : thr - hys;
      hi   = (thr + hys > MAXV) ? MAXV : thr + hys;
      armh = fall ? (d > hi) : (d < lo);
      lvl  = fall ? (d <= thr) : (d >= thr);
      swap_now = 0;
      if (acc && m_phase != 3) begin
        hist.push_back(d);
        if (hist.size() > DEPTH) void'(hist.pop_front());
      end
      case (m_phase)
        0: if (acc) begin
             if (armh) m_arm = 1;
             m_cnt++;
             if (m_cnt == PRE) begin m_phase = 1; m_waited = 0; end
           end
        1: if (acc) begin
             fire = (m_arm && lvl) || (mode == 2'd1 && m_waited >= TIMEOUT);
             if (fire) begin
               exp_trig = 1; m_fires++; m_fire_val = d; m_phase = 2; m_cnt = 0;
             end else begin
               if (armh) m_arm = 1;
               m_waited++;
             end
           end
        2: if (acc) begin
             m_cnt++;
             if (m_cnt == DEPTH - PRE - 1) swap_now = 1;
           end
        default: if (rearm && !hold) begin m_phase = 0; m_cnt = 0; m_arm = 0; end
      endcase
      if (swap_now) begin
        for (int i = 0; i < DEPTH; i++) disp[i] = hist[hist.size() - DEPTH + i];
        m_fv = 1; m_res = !m_res;
        m_phase = (mode == 2'd2) ? 3 : 0;
        m_cnt = 0; m_arm = 0;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("screenData", int'(screenData), exp_scr);
      check("triggered", int'(triggered), int'(exp_trig));
      check("resample", int'(resample), int'(m_res));
      check("frameValid", int'(frameValid), int'(m_fv));
    end
  end

  // ---------------- DUT event monitor ----------------
  int edge_data = 0, acc_cnt = 0;
  int dut_trigs = 0, dut_trig_val = -1, dut_trig_acc = 0;

  always @(posedge clock) begin
    edge_data <= int'(data);
    if (reset && sampleEn && !hold) acc_cnt <= acc_cnt + 1;
  end

  always @(negedge clock) begin
    if (chk_en && triggered === 1'b1) begin
      dut_trigs++;
      dut_trig_val = edge_data;
      dut_trig_acc = acc_cnt;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clock);
    reset = 0; sampleEn = 0; hold = 0; rearm = 0;
    @(negedge clock);
    reset = 1;
  endtask

  task automatic push(input int d);
    @(negedge clock);
    sampleEn = 1; hold = 0; rearm = 0; data = DATA_W'(d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      sampleEn = 0; rearm = 0;
    end
  endtask

  task automatic ramp(input int from, input int to, input int step);
    if (step > 0) for (int v = from; v <= to; v += step) push(v);
    else          for (int v = from; v >= to; v += step) push(v);
  endtask

  task automatic read_x(input string name, input int x, input int exp);
    @(negedge clock);
    sampleEn = 0; screenX = ADDR_W'(x);
    @(negedge clock);
    check(name, int'(screenData), exp);
  endtask

  int t0, base;

  initial begin
    triggerThreshold = 12'd100; hysteresis = 12'd10;
    repeat (2) @(negedge clock);
    reset = 1;

    // Reset state
    idle(1);
    check("reset_frameValid", int'(frameValid), 0);
    check("reset_resample", int'(resample), 0);
    check("reset_screenData", int'(screenData), 0);

    // Rising ramp, normal mode: fire on 100, frame 80..155
    triggerEdge = 0; mode = 2'd0;
    t0 = dut_trigs;
    ramp(0, 155, 5);
    idle(2);
    check("rise_trig_count", dut_trigs - t0, 1);
    check("rise_trig_value", dut_trig_val, 100);
    check("rise_model_value", m_fire_val, 100);
    check("rise_resample", int'(resample), 1);
    check("rise_frameValid", int'(frameValid), 1);
    read_x("rise_x4", 4, 100);
    read_x("rise_x0", 0, 80);
    read_x("rise_x15", 15, 155);
    read_x("rise_x20_out", 20, 0);

    // Falling ramp: fire at 100, then no re-arm above 110 -> no second fire
    triggerEdge = 1;
    t0 = dut_trigs;
    ramp(200, 45, -5);
    idle(2);
    check("fall_trig_count", dut_trigs - t0, 1);
    check("fall_trig_value", dut_trig_val, 100);
    check("fall_resample", int'(resample), 0);
    read_x("fall_x4", 4, 100);
    read_x("fall_x0", 0, 120);
    t0 = dut_trigs;
    for (int i = 0; i < 30; i++) push((i % 2 == 0) ? 100 : 105);
    idle(2);
    check("fall_no_rearm", dut_trigs - t0, 0);

    // Auto: constant 50 forces fire on 21st armed sample (25th overall)
    do_reset();
    triggerEdge = 0; mode = 2'd1;
    base = acc_cnt; t0 = dut_trigs;
    repeat (25) push(50);
    idle(2);
    check("auto_trig_count", dut_trigs - t0, 1);
    check("auto_trig_sample", dut_trig_acc - base, 25);
    repeat (10) push(50);
    idle(2);
    check("auto_fv_before", int'(frameValid), 0);
    push(50);
    idle(2);
    check("auto_fv_after", int'(frameValid), 1);

    // Single shot: one frame, ignore triggers in WAIT, rearm restarts
    do_reset();
    mode = 2'd2;
    t0 = dut_trigs;
    ramp(0, 155, 5);
    idle(2);
    check("single_trig1", dut_trigs - t0, 1);
    check("single_res1", int'(resample), 1);
    ramp(0, 255, 5);
    idle(2);
    check("single_ignored", dut_trigs - t0, 1);
    check("single_res_hold", int'(resample), 1);
    @(negedge clock); sampleEn = 0; rearm = 1;
    idle(1);
    ramp(0, 155, 5);
    idle(2);
    check("single_trig2", dut_trigs - t0, 2);
    check("single_res2", int'(resample), 0);

    // Hold in POST: no writes, no swap; frame intact afterwards
    do_reset();
    mode = 2'd0;
    ramp(0, 110, 5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      hold = 1; sampleEn = 1; data = 12'd4000;
    end
    @(negedge clock);
    check("hold_no_swap", int'(resample), 0);
    check("hold_fv", int'(frameValid), 0);
    hold = 0; sampleEn = 1; data = 12'd115;
    ramp(120, 155, 5);
    idle(2);
    check("hold_resume_swap", int'(resample), 1);
    for (int x = 0; x < DEPTH; x++) read_x("hold_frame", x, 80 + 5 * x);

    // Reset during POST
    ramp(0, 110, 5);
    @(negedge clock);
    reset = 0; sampleEn = 1; data = 12'd7;
    @(negedge clock);
    check("rst_triggered", int'(triggered), 0);
    check("rst_resample", int'(resample), 0);
    check("rst_frameValid", int'(frameValid), 0);
    check("rst_screenData", int'(screenData), 0);
    reset = 1; sampleEn = 0;
    for (int x = 0; x < (1 << ADDR_W); x++) read_x("rst_read", x, 0);

    // Randomized traffic against the model
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(negedge clock);
      if (cyc % 300 == 0) begin
        mode = 2'($urandom_range(0, 3));
        triggerEdge = 1'($urandom_range(0, 1));
        triggerThreshold = DATA_W'($urandom_range(20, 4080));
        hysteresis = ($urandom_range(0, 9) == 0) ? DATA_W'($urandom_range(100, 4095))
                                                 : DATA_W'($urandom_range(0, 50));
      end
      reset    = ($urandom_range(0, 599) != 0);
      sampleEn = ($urandom_range(0, 3) != 0);
      hold     = ($urandom_range(0, 19) == 0);
      rearm    = ($urandom_range(0, 29) == 0);
      screenX  = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
      if ($urandom_range(0, 4) == 0) data = DATA_W'($urandom_range(0, MAXV));
      else begin
        int v;
        v = int'(triggerThreshold) + int'($urandom_range(0, 160)) - 80;
        if (v < 0) v = 0;
        if (v > MAXV) v = MAXV;
        data = DATA_W'(v);
      end
    end
    reset = 1;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
